// File: rtl/load_store_unit.sv
// load_store_unit
//   Sits between the execute stage and a simple request/grant memory bus.
//   It accepts one RV32I load or store at a time. It checks alignment and
//   funct3 legality, and builds the word-aligned bus transaction with byte
//   enables and lane-replicated write data. It then waits for the bus
//   completion, or gives up after BUS_TIMEOUT cycles. The result goes back
//   as a response with the load data already extracted and extended.
//
// Parameters
//   BUS_TIMEOUT   cycles spent in REQ+WAIT before the operation is aborted
//
// Ports
//   clk_in, rst_n_in            clock, asynchronous active-low reset
//   req_valid_in/req_ready_out  request handshake from execute
//   req_we_in, req_funct3_in    store flag and width/sign code
//   addr_in, wdata_in           byte address and store data
//   rsp_valid_out/rsp_ready_in  response handshake to writeback
//   rsp_rdata_out, rsp_err_out  load result and error code
//   bus_req_out .. bus_wdata_out  bus request side
//   bus_gnt_in .. bus_err_in      bus grant and completion side
module load_store_unit #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_we_in,
  input  logic [2:0]  req_funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        rsp_valid_out,
  input  logic        rsp_ready_in,
  output logic [31:0] rsp_rdata_out,
  output logic [1:0]  rsp_err_out,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [3:0]  bus_be_out,
  output logic [31:0] bus_wdata_out,
  input  logic        bus_gnt_in,
  input  logic        bus_rvalid_in,
  input  logic [31:0] bus_rdata_in,
  input  logic        bus_err_in
);

  localparam int CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic          op_we;
  logic [2:0]    op_funct3;
  logic [1:0]    op_off;

  logic          illegal;
  logic          misaligned;
  logic [3:0]    be_calc;
  logic [31:0]   wdata_calc;
  logic [31:0]   lane;
  logic [31:0]   load_data;
  logic [31:0]   done_rdata;
  logic [1:0]    done_err;

  // Handshake and bus-request outputs are pure decodes of the state
  // register, so reset forces them to their idle values at once.
  assign req_ready_out = (state == IDLE);
  assign bus_req_out   = (state == REQ);
  assign rsp_valid_out = (state == RESP);

  // Decode the incoming request: legality, alignment, lane enables and
  // write-data replication. funct3[1:0] selects the access size.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    be_calc    = 4'b0000;
    wdata_calc = wdata_in;
    if (req_we_in)
      illegal = (req_funct3_in > 3'b010);
    else
      illegal = (req_funct3_in == 3'b011) || (req_funct3_in[2:1] == 2'b11);
    case (req_funct3_in[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr_in[1:0];
        wdata_calc = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        misaligned = addr_in[0];
        be_calc    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{wdata_in[15:0]}};
      end
      default: begin
        misaligned = |addr_in[1:0];
        be_calc    = 4'b1111;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend it according to
  // the latched funct3. Stores and faulted accesses return zero.
  always_comb begin
    lane = bus_rdata_in >> {op_off, 3'b000};
    case (op_funct3)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'h0, lane[7:0]};
      3'b101:  load_data = {16'h0, lane[15:0]};
      default: load_data = lane;
    endcase
    done_rdata = (op_we || bus_err_in) ? 32'h0 : load_data;
    done_err   = bus_err_in ? 2'b10 : 2'b00;
  end

  // Main FSM. The bus completes in REQ (grant and rvalid together) or in
  // WAIT. A completion on the last allowed cycle wins over the timeout.
  // Grant and rvalid are not looked at in IDLE or RESP, so a late
  // completion after a timeout is dropped.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      op_we         <= 1'b0;
      op_funct3     <= 3'b000;
      op_off        <= 2'b00;
      bus_we_out    <= 1'b0;
      bus_addr_out  <= 32'h0;
      bus_be_out    <= 4'b0000;
      bus_wdata_out <= 32'h0;
      rsp_rdata_out <= 32'h0;
      rsp_err_out   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_in) begin
            op_we     <= req_we_in;
            op_funct3 <= req_funct3_in;
            op_off    <= addr_in[1:0];
            tmo_cnt   <= '0;
            if (illegal) begin
              state         <= RESP;
              rsp_err_out   <= 2'b10;
              rsp_rdata_out <= 32'h0;
            end else if (misaligned) begin
              state         <= RESP;
              rsp_err_out   <= 2'b01;
              rsp_rdata_out <= 32'h0;
            end else begin
              state         <= REQ;
              bus_we_out    <= req_we_in;
              bus_addr_out  <= {addr_in[31:2], 2'b00};
              bus_be_out    <= be_calc;
              bus_wdata_out <= wdata_calc;
            end
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + CW'(1);
          if (bus_gnt_in && bus_rvalid_in) begin
            state         <= RESP;
            rsp_rdata_out <= done_rdata;
            rsp_err_out   <= done_err;
          end else if (bus_gnt_in) begin
            state <= WAIT;
          end else if (tmo_cnt >= TMO_LAST) begin
            state         <= RESP;
            rsp_rdata_out <= 32'h0;
            rsp_err_out   <= 2'b11;
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + CW'(1);
          if (bus_rvalid_in) begin
            state         <= RESP;
            rsp_rdata_out <= done_rdata;
            rsp_err_out   <= done_err;
          end else if (tmo_cnt >= TMO_LAST) begin
            state         <= RESP;
            rsp_rdata_out <= 32'h0;
            rsp_err_out   <= 2'b11;
          end
        end
        RESP: begin
          if (rsp_ready_in)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Self-checking bench for load_store_unit with BUS_TIMEOUT = 8.
//   Each operation pushes its expected response into a scoreboard queue
//   when it is driven. A monitor pops and compares the entry whenever the
//   response handshake fires. Bus-side fields and cycle timing are checked
//   inline by the stimulus tasks.
module tb_load_store_unit;

  localparam int TMO = 8;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_we_in;
  logic [2:0]  req_funct3_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        rsp_valid_out;
  logic        rsp_ready_in;
  logic [31:0] rsp_rdata_out;
  logic [1:0]  rsp_err_out;
  logic        bus_req_out;
  logic        bus_we_out;
  logic [31:0] bus_addr_out;
  logic [3:0]  bus_be_out;
  logic [31:0] bus_wdata_out;
  logic        bus_gnt_in;
  logic        bus_rvalid_in;
  logic [31:0] bus_rdata_in;
  logic        bus_err_in;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  load_store_unit #(.BUS_TIMEOUT(TMO)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_we_in     (req_we_in),
    .req_funct3_in (req_funct3_in),
    .addr_in       (addr_in),
    .wdata_in      (wdata_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_ready_in  (rsp_ready_in),
    .rsp_rdata_out (rsp_rdata_out),
    .rsp_err_out   (rsp_err_out),
    .bus_req_out   (bus_req_out),
    .bus_we_out    (bus_we_out),
    .bus_addr_out  (bus_addr_out),
    .bus_be_out    (bus_be_out),
    .bus_wdata_out (bus_wdata_out),
    .bus_gnt_in    (bus_gnt_in),
    .bus_rvalid_in (bus_rvalid_in),
    .bus_rdata_in  (bus_rdata_in),
    .bus_err_in    (bus_err_in)
  );

  // 10 ns clock
  always #5 clk_in = ~clk_in;

  // Counts every comparison and reports a mismatch on one line
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Reference model: error code for a request
  function automatic logic [1:0] expErr(input logic we, input logic [2:0] f3,
                                        input logic [31:0] addr);
    logic bad;
    if (we) bad = (f3 == 3'b011) || f3[2];
    else    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if (bad) return 2'b10;
    if (f3[1:0] == 2'b01 && addr[0] == 1'b1) return 2'b01;
    if (f3[1:0] == 2'b10 && addr[1:0] != 2'b00) return 2'b01;
    return 2'b00;
  endfunction

  // Reference model: byte enables
  function automatic logic [3:0] expBe(input logic [2:0] f3, input logic [31:0] addr);
    if (f3[1:0] == 2'b00) begin
      case (addr[1:0])
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (f3[1:0] == 2'b01) return addr[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Reference model: write data lanes
  function automatic logic [31:0] expWdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1:0] == 2'b00) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    if (f3[1:0] == 2'b01) return {wd[15:0], wd[15:0]};
    return wd;
  endfunction

  // Reference model: extended load result
  function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*addr[1:0] +: 8];
    h = addr[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  // Scoreboard monitor: compare on every response handshake
  always @(negedge clk_in) begin
    if (rst_n_in && rsp_valid_out && rsp_ready_in) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("rsp_rdata", rsp_rdata_out, e.rdata);
        checkOutput("rsp_err", {30'h0, rsp_err_out}, {30'h0, e.err});
      end
    end
  end

  // Drive one request for the current cycle. When push is set, the
  // expected response goes into the scoreboard.
  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic berr,
                               input logic push);
    exp_t e;
    req_valid_in  = 1'b1;
    req_we_in     = we;
    req_funct3_in = f3;
    addr_in       = addr;
    wdata_in      = wdata;
    e.err   = expErr(we, f3, addr);
    e.rdata = 32'h0;
    if (e.err == 2'b00) begin
      if (berr)    e.err = 2'b10;
      else if (!we) e.rdata = expLoad(f3, addr, rdata);
    end
    if (push) sb.push_back(e);
  endtask

  // Full operation. Grant comes after gnt_lat REQ cycles. rvalid comes
  // with the grant (rv_lat = 0) or in WAIT cycle rv_lat. The response is
  // then held for hold cycles before writeback accepts it.
  task automatic runOp(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input logic berr, input int gnt_lat, input int rv_lat,
                       input int hold);
    logic [1:0]  err;
    logic [31:0] held;
    err = expErr(we, f3, addr);
    checkOutput("ready_idle", {31'h0, req_ready_out}, 32'd1);
    applyStimulus(we, f3, addr, wdata, rdata, berr, 1'b1);
    step();
    req_valid_in = 1'b0;
    if (err != 2'b00) begin
      checkOutput("short_no_busreq", {31'h0, bus_req_out}, 32'd0);
      checkOutput("short_rsp_c1", {31'h0, rsp_valid_out}, 32'd1);
    end else begin
      checkOutput("busreq_c1", {31'h0, bus_req_out}, 32'd1);
      checkOutput("bus_addr", bus_addr_out, {addr[31:2], 2'b00});
      checkOutput("bus_be", {28'h0, bus_be_out}, {28'h0, expBe(f3, addr)});
      checkOutput("bus_we", {31'h0, bus_we_out}, {31'h0, we});
      if (we) checkOutput("bus_wdata", bus_wdata_out, expWdata(f3, wdata));
      repeat (gnt_lat) begin
        step();
        checkOutput("busreq_hold", {31'h0, bus_req_out}, 32'd1);
        checkOutput("bus_addr_hold", bus_addr_out, {addr[31:2], 2'b00});
      end
      bus_gnt_in = 1'b1;
      if (rv_lat == 0) begin
        bus_rvalid_in = 1'b1;
        bus_rdata_in  = rdata;
        bus_err_in    = berr;
      end
      step();
      bus_gnt_in    = 1'b0;
      bus_rvalid_in = 1'b0;
      bus_err_in    = 1'b0;
      bus_rdata_in  = 32'hDEAD_0000;
      if (rv_lat > 0) begin
        checkOutput("busreq_wait", {31'h0, bus_req_out}, 32'd0);
        checkOutput("rsp_not_yet", {31'h0, rsp_valid_out}, 32'd0);
        repeat (rv_lat - 1) step();
        bus_rvalid_in = 1'b1;
        bus_rdata_in  = rdata;
        bus_err_in    = berr;
        step();
        bus_rvalid_in = 1'b0;
        bus_err_in    = 1'b0;
        bus_rdata_in  = 32'hDEAD_0000;
      end
      checkOutput("rsp_valid", {31'h0, rsp_valid_out}, 32'd1);
      checkOutput("busreq_resp", {31'h0, bus_req_out}, 32'd0);
    end
    held = rsp_rdata_out;
    repeat (hold) begin
      // a competing request must not be taken while the response waits
      req_valid_in  = 1'b1;
      req_we_in     = 1'b0;
      req_funct3_in = 3'b010;
      addr_in       = 32'h0000_7000;
      step();
      checkOutput("hold_valid", {31'h0, rsp_valid_out}, 32'd1);
      checkOutput("hold_ready", {31'h0, req_ready_out}, 32'd0);
      checkOutput("hold_data", rsp_rdata_out, held);
      checkOutput("hold_busreq", {31'h0, bus_req_out}, 32'd0);
    end
    req_valid_in = 1'b0;
    rsp_ready_in = 1'b1;
    step();
    rsp_ready_in = 1'b0;
    checkOutput("ready_after", {31'h0, req_ready_out}, 32'd1);
    checkOutput("rsp_drop", {31'h0, rsp_valid_out}, 32'd0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n_in      = 1'b0;
    req_valid_in  = 1'b0;
    req_we_in     = 1'b0;
    req_funct3_in = 3'b000;
    addr_in       = 32'h0;
    wdata_in      = 32'h0;
    rsp_ready_in  = 1'b0;
    bus_gnt_in    = 1'b0;
    bus_rvalid_in = 1'b0;
    bus_rdata_in  = 32'h0;
    bus_err_in    = 1'b0;

    // Reset state
    #2;
    checkOutput("rst_ready", {31'h0, req_ready_out}, 32'd1);
    checkOutput("rst_busreq", {31'h0, bus_req_out}, 32'd0);
    checkOutput("rst_rspvalid", {31'h0, rsp_valid_out}, 32'd0);
    checkOutput("rst_rdata", rsp_rdata_out, 32'h0);
    checkOutput("rst_err", {30'h0, rsp_err_out}, 32'h0);
    checkOutput("rst_addr", bus_addr_out, 32'h0);
    checkOutput("rst_be", {28'h0, bus_be_out}, 32'h0);
    checkOutput("rst_wdata", bus_wdata_out, 32'h0);
    checkOutput("rst_we", {31'h0, bus_we_out}, 32'h0);
    step();
    step();
    rst_n_in = 1'b1;
    step();

    // LB 0x1003, minimum latency
    runOp(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 1'b0, 0, 0, 0);
    // SH 0x2002
    runOp(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 1'b0, 1, 0, 0);
    // Misaligned LW and LHU
    runOp(1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    runOp(1'b0, 3'b101, 32'h0000_3001, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    // Extension variants with slower bus
    runOp(1'b0, 3'b100, 32'h0000_1001, 32'h0, 32'h80AA_BBCC, 1'b0, 2, 3, 0);
    runOp(1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h80AA_BBCC, 1'b0, 0, 1, 0);
    runOp(1'b0, 3'b101, 32'h0000_1002, 32'h0, 32'h80AA_BBCC, 1'b0, 1, 2, 0);
    runOp(1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'h8123_4567, 1'b0, 0, 0, 0);
    // Bus error on a load
    runOp(1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'h1234_5678, 1'b1, 0, 2, 0);
    // SB and SW
    runOp(1'b1, 3'b000, 32'h0000_5001, 32'h0000_00A5, 32'h0, 1'b0, 0, 0, 0);
    runOp(1'b1, 3'b010, 32'h0000_5004, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, 1, 0);
    // Illegal funct3
    runOp(1'b0, 3'b011, 32'h0000_6000, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    runOp(1'b1, 3'b100, 32'h0000_6000, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    runOp(1'b1, 3'b011, 32'h0000_6000, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    // Back-pressure: response held for 5 cycles
    runOp(1'b0, 3'b000, 32'h0000_1002, 32'h0, 32'h80AA_BBCC, 1'b0, 0, 0, 5);

    // Timeout: LW with a silent bus
    checkOutput("tmo_ready", {31'h0, req_ready_out}, 32'd1);
    applyStimulus(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 1'b0, 1'b0);
    sb.push_back('{rdata: 32'h0, err: 2'b11});
    step();
    req_valid_in = 1'b0;
    repeat (TMO - 1) step();
    checkOutput("tmo_busreq_last", {31'h0, bus_req_out}, 32'd1);
    checkOutput("tmo_no_rsp_yet", {31'h0, rsp_valid_out}, 32'd0);
    step();
    checkOutput("tmo_busreq_drop", {31'h0, bus_req_out}, 32'd0);
    checkOutput("tmo_rsp_valid", {31'h0, rsp_valid_out}, 32'd1);
    // A late completion in RESP must be ignored
    bus_gnt_in    = 1'b1;
    bus_rvalid_in = 1'b1;
    bus_rdata_in  = 32'hCAFE_F00D;
    step();
    bus_gnt_in    = 1'b0;
    bus_rvalid_in = 1'b0;
    checkOutput("tmo_late_err", {30'h0, rsp_err_out}, 32'd3);
    checkOutput("tmo_late_rdata", rsp_rdata_out, 32'h0);
    rsp_ready_in = 1'b1;
    step();
    rsp_ready_in = 1'b0;
    checkOutput("tmo_ready_after", {31'h0, req_ready_out}, 32'd1);
    // A completion in IDLE must be ignored too
    bus_gnt_in    = 1'b1;
    bus_rvalid_in = 1'b1;
    step();
    bus_gnt_in    = 1'b0;
    bus_rvalid_in = 1'b0;
    checkOutput("idle_ignore_rv", {31'h0, rsp_valid_out}, 32'd0);
    checkOutput("idle_ignore_gnt", {31'h0, req_ready_out}, 32'd1);

    // Reset pulsed while in WAIT
    applyStimulus(1'b0, 3'b010, 32'h0000_8000, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    req_valid_in = 1'b0;
    bus_gnt_in   = 1'b1;
    step();
    bus_gnt_in = 1'b0;
    checkOutput("wait_busreq", {31'h0, bus_req_out}, 32'd0);
    checkOutput("wait_notready", {31'h0, req_ready_out}, 32'd0);
    rst_n_in = 1'b0;
    #1;
    checkOutput("arst_wait_busreq", {31'h0, bus_req_out}, 32'd0);
    checkOutput("arst_wait_rsp", {31'h0, rsp_valid_out}, 32'd0);
    checkOutput("arst_wait_err", {30'h0, rsp_err_out}, 32'd0);
    checkOutput("arst_wait_ready", {31'h0, req_ready_out}, 32'd1);
    checkOutput("arst_wait_be", {28'h0, bus_be_out}, 32'd0);
    step();
    rst_n_in = 1'b1;
    step();
    runOp(1'b0, 3'b010, 32'h0000_8000, 32'h0, 32'h0BAD_CAFE, 1'b0, 0, 1, 0);

    // Reset pulsed while a misaligned response is pending
    applyStimulus(1'b0, 3'b010, 32'h0000_8002, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    req_valid_in = 1'b0;
    checkOutput("pre_rst_rsp", {31'h0, rsp_valid_out}, 32'd1);
    checkOutput("pre_rst_err", {30'h0, rsp_err_out}, 32'd1);
    rst_n_in = 1'b0;
    #1;
    checkOutput("arst_resp_valid", {31'h0, rsp_valid_out}, 32'd0);
    checkOutput("arst_resp_err", {30'h0, rsp_err_out}, 32'd0);
    step();
    rst_n_in = 1'b1;
    step();

    // Random operations with varied bus latency and back-pressure
    for (int i = 0; i < 24; i++) begin
      runOp(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
            $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 2),
            $urandom_range(0, 3), $urandom_range(0, 2));
    end

    step();
    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter BUS_TIMEOUT, default 255: number of bus cycles the block waits before aborting with a timeout error.
REQ-002 clk_in  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n_in  input  1  reset; asynchronous, active-low.
REQ-004 req_valid_in  input  1  execute stage presents a memory operation.
REQ-005 req_ready_out  output  1  block can accept a request this cycle.
REQ-006 req_we_in  input  1  1 = store, 0 = load.
REQ-007 req_funct3_in  input  3  RV32I width/sign code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-008 addr_in  input  32  effective byte address (ALU result).
REQ-009 wdata_in  input  32  store data (rs2).
REQ-010 rsp_valid_out  output  1  response available.
REQ-011 rsp_ready_in  input  1  writeback stage accepts the response.
REQ-012 rsp_rdata_out  output  32  load result, already extended.
REQ-013 rsp_err_out  output  2  error code: 00 OK, 01 misaligned, 10 bus error or illegal funct3, 11 timeout.
REQ-014 bus_req_out  output  1  bus request.
REQ-015 bus_we_out  output  1  bus write.
REQ-016 bus_addr_out  output  32  word-aligned address; bits [1:0] are always 00.
REQ-017 bus_be_out  output  4  byte enables.
REQ-018 bus_wdata_out  output  32  lane-replicated write data.
REQ-019 bus_gnt_in  input  1  bus accepts the request.
REQ-020 bus_rvalid_in  input  1  bus completion.
REQ-021 bus_rdata_in  input  32  read data, valid with bus_rvalid_in.
REQ-022 bus_err_in  input  1  bus fault, valid with bus_rvalid_in.

Function
REQ-023 The FSM SHALL have four states: IDLE, REQ, WAIT and RESP.
REQ-024 req_ready_out SHALL be 1 only in IDLE; a request is accepted when req_valid_in and req_ready_out are both 1.
REQ-025 On accept of a legal, aligned operation, the FSM SHALL go to REQ and register bus_addr_out, bus_we_out, bus_be_out and bus_wdata_out, all held stable while bus_req_out is 1.
REQ-026 Operations that are misaligned (half with addr[0]=1; word with addr[1:0]≠00) or that use an illegal funct3 (load 011/110/111; store ≥011) SHALL go directly to RESP with error 01 or 10 respectively, with no bus access.
REQ-027 Byte enables: byte ops = 1<<addr[1:0]; half ops = 0011 when addr[1]=0, else 1100; word ops = 1111.
REQ-028 Write data: SB replicates wdata[7:0] to all 4 lanes; SH replicates wdata[15:0] to both halves; SW passes wdata unchanged.
REQ-029 In REQ, bus_req_out SHALL be 1; on bus_gnt_in the FSM goes to WAIT, or directly to RESP if bus_rvalid_in is also 1 in the same cycle.
REQ-030 In WAIT, bus_req_out SHALL be 0; on bus_rvalid_in the FSM captures data and error and goes to RESP.
REQ-031 Load data SHALL be extracted from the addressed lane; LB/LH sign-extend, LBU/LHU zero-extend, LW passes unchanged.
REQ-032 Stores SHALL return rsp_rdata_out = 0.
REQ-033 If bus_err_in=1 with bus_rvalid_in, the response SHALL be error 10 with rsp_rdata_out = 0.
REQ-034 A timeout counter SHALL clear on accept and increment each cycle in REQ or WAIT; when it reaches BUS_TIMEOUT the FSM drops bus_req_out and goes to RESP with error 11 and rdata 0.
REQ-035 bus_gnt_in and bus_rvalid_in SHALL be ignored in IDLE and RESP, so a late completion after a timeout is discarded.
REQ-036 In RESP, rsp_valid_out SHALL be 1 and rsp_rdata_out and rsp_err_out held stable until rsp_ready_in=1; the FSM then returns to IDLE.
REQ-037 Minimum latency SHALL be: accept in cycle 0, bus_req_out in cycle 1, rsp_valid_out in cycle 2 when gnt and rvalid both arrive in cycle 1; an error short-cut gives rsp_valid_out in cycle 1.
REQ-038 The block SHALL have no pipelining; at most one operation is outstanding.

Reset
REQ-039 While rst_n_in=0: state = IDLE, req_ready_out=1, and every other output and the timeout counter are 0, immediately and independent of the clock.
REQ-040 Reset asserted mid-operation SHALL drop bus_req_out and rsp_valid_out asynchronously and discard the operation.

Verification
REQ-041 LB, addr 0x1003, bus_rdata 0x80AA_BBCC, gnt and rvalid in cycle 1 -> be 1000, bus_addr 0x1000, rdata 0xFFFF_FF80, err 00, rsp_valid in cycle 2.
REQ-042 SH, addr 0x2002, wdata 0x1234_ABCD -> be 1100, bus_wdata 0xABCD_ABCD, bus_we=1, rdata 0, err 00.
REQ-043 LW, addr 0x3001 -> no bus_req_out; rsp_valid in cycle 1 with err 01; LHU with addr[0]=1 gives the same result.
REQ-044 LW, bus never responds, BUS_TIMEOUT=8 -> bus_req_out drops, err 11 after 8 cycles; a later rvalid is ignored and req_ready_out=1 after the handshake.
REQ-045 rsp_ready_in held at 0 for 5 cycles -> rsp_valid_out and data stable, req_ready_out=0; a new req_valid_in is not accepted until RESP completes.
REQ-046 rst_n_in pulsed low while in WAIT -> bus_req_out, rsp_valid_out and rsp_err_out go to 0 at once; the next LW completes normally.
